// File: rtl/spi_ctrl_pkg.sv
// Shared types and defaults for the SPI transfer controller.
package spi_ctrl_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DIV_W  = 8;
  localparam int LEN_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    RESP
  } state_t;

endpackage

// File: rtl/spi_div_cnt.sv
// Half-period timer: ticks on the last cycle of every (load value + 1) cycle window.
module spi_div_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_period;
  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == '0);

  // Counts down to zero and reloads, so an all-ones period never overflows.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_period <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_period <= i_load_val;
      r_cnt    <= i_load_val;
    end else if (i_en) begin
      if (r_cnt == '0) r_cnt <= r_period;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master: one command in, one frame of up to 16 bits on the wire, one response out.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DIV_W-1:0]  cmd_div,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sck,
  output logic              ss,
  output logic              mosi,
  input  logic              miso,
  output logic              busy
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [LEN_W-1:0]  r_bitsLeft;
  logic [31:0]       w_shift;
  logic [DATA_W-1:0] w_txAligned;
  logic              w_accept;
  logic              w_timed;
  logic              w_tick;

  assign w_accept    = cmd_valid && (r_state == IDLE);
  assign w_timed     = (r_state == SETUP) || (r_state == HIGH) ||
                       (r_state == LOW)   || (r_state == HOLD);
  assign w_shift     = 32'(DATA_W - 1) - 32'(cmd_len);
  // Left-align the frame so the first bit to send is always the register MSB.
  assign w_txAligned = cmd_wdata << w_shift;
  assign rsp_rdata   = r_rx;

  spi_div_cnt #(.DIV_W(DIV_W)) u_div (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_accept),
    .i_load_val (cmd_div),
    .i_en       (w_timed),
    .o_tick     (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    sck       = 1'b0;
    ss        = 1'b1;
    mosi      = 1'b0;
    busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = SETUP;
      end
      SETUP: begin
        ss   = 1'b0;
        mosi = r_tx[DATA_W-1];
        if (w_tick) w_next = HIGH;
      end
      HIGH: begin
        ss   = 1'b0;
        sck  = 1'b1;
        mosi = r_tx[DATA_W-1];
        if (w_tick) w_next = (r_bitsLeft == '0) ? HOLD : LOW;
      end
      LOW: begin
        ss   = 1'b0;
        mosi = r_tx[DATA_W-1];
        if (w_tick) w_next = HIGH;
      end
      HOLD: begin
        ss = 1'b0;
        if (w_tick) w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Sample and shift on the closing cycle of each high phase; mosi then moves as sck falls.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_bitsLeft <= '0;
    end else if (w_accept) begin
      r_tx       <= w_txAligned;
      r_rx       <= '0;
      r_bitsLeft <= cmd_len;
    end else if ((r_state == HIGH) && w_tick) begin
      r_rx <= {r_rx[DATA_W-2:0], miso};
      r_tx <= r_tx << 1;
      if (r_bitsLeft != '0) r_bitsLeft <= r_bitsLeft - 1'b1;
    end
  end

endmodule
